// File: rtl/router_port_arbiter.sv
// Per-destination-port round-robin packet arbiter: holds a grant for a whole
// packet by counting the granted source's byte strobes against its len field.
module router_port_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned MIN_LEN = 10,
    parameter int unsigned MAX_LEN = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 port_en,
    input  logic [NUM_SRC-1:0]   req,
    input  logic [32*NUM_SRC-1:0] pkt_len,
    input  logic [NUM_SRC-1:0]   in_valid,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 busy,
    output logic                 pkt_done,
    output logic [1:0]           last_src,
    output logic [31:0]          pkt_count
);

    localparam int unsigned SRC_W = 2;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LEN_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               pkt_done_q, pkt_done_d;
    logic [SRC_W-1:0]   last_src_q, last_src_d;
    logic [LEN_W-1:0]   pkt_count_q, pkt_count_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_SRC-1:0] eligible;
    logic               win_found;
    logic [SRC_W-1:0]   win_idx;
    logic [SRC_W-1:0]   scan_idx;
    logic [LEN_W-1:0]   win_len;

    // Saturate the header length field into the 8-bit beat budget
    function automatic logic [CNT_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len < LEN_W'(MIN_LEN)) begin
            return CNT_W'(MIN_LEN);
        end else if (len > LEN_W'(MAX_LEN)) begin
            return CNT_W'(MAX_LEN);
        end else begin
            return CNT_W'(len);
        end
    endfunction

    // Round-robin pick: first eligible source scanning upward from ptr
    always_comb begin
        eligible  = req & {NUM_SRC{port_en}};
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            scan_idx = ptr_q + SRC_W'(k);
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
        win_len = pkt_len[LEN_W*win_idx +: LEN_W];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        pkt_done_d  = 1'b0;
        last_src_d  = last_src_q;
        pkt_count_d = pkt_count_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    last_src_d       = win_idx;
                    cnt_d            = clamp_len(win_len);
                    state_d          = XFER;
                end
            end
            XFER: begin
                if (in_valid[last_src_q]) begin
                    if (cnt_q == CNT_W'(1)) begin
                        grant_d     = '0;
                        pkt_done_d  = 1'b1;
                        pkt_count_d = pkt_count_q + LEN_W'(1);
                        ptr_d       = last_src_q + SRC_W'(1);
                        cnt_d       = '0;
                        state_d     = GAP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
            last_src_q  <= '0;
            pkt_count_q <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            pkt_done_q  <= pkt_done_d;
            last_src_q  <= last_src_d;
            pkt_count_q <= pkt_count_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign pkt_done  = pkt_done_q;
    assign last_src  = last_src_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed bench for router_port_arbiter.
module tb_router_port_arbiter;

    logic         clk;
    logic         reset;
    logic         port_en;
    logic [3:0]   req;
    logic [127:0] pkt_len;
    logic [3:0]   in_valid;
    logic [3:0]   grant;
    logic         busy;
    logic         pkt_done;
    logic [1:0]   last_src;
    logic [31:0]  pkt_count;

    int checks = 0;
    int errors = 0;
    int nbeats;

    router_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .port_en   (port_en),
        .req       (req),
        .pkt_len   (pkt_len),
        .in_valid  (in_valid),
        .grant     (grant),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .last_src  (last_src),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        req      = '0;
        in_valid = '0;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    // Strobe the given source every cycle until the grant drops (bounded)
    task automatic beats_until_release(input int src, input int maxb, output int n);
        n = 0;
        in_valid = '0;
        in_valid[src] = 1'b1;
        while (grant != 4'b0000 && n < maxb) begin
            step(1);
            n++;
        end
        in_valid = '0;
    endtask

    initial begin
        reset    = 1'b0;
        port_en  = 1'b1;
        req      = '0;
        pkt_len  = '0;
        in_valid = '0;
        step(1);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(pkt_done), 32'h0);
        chk("rst_last", 32'(last_src), 32'h0);
        chk("rst_count", pkt_count, 32'h0);
        reset = 1'b1;
        step(1);

        // 1: single packet from source 0, 20 beats
        for (int i = 0; i < 4; i++) pkt_len[32*i +: 32] = 32'd20;
        req = 4'b0001;
        step(1);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        req = '0;
        beats_until_release(0, 40, nbeats);
        chk("t1_beats", 32'(nbeats), 32'd20);
        chk("t1_done", 32'(pkt_done), 32'h1);
        chk("t1_count", pkt_count, 32'd1);
        chk("t1_last", 32'(last_src), 32'h0);
        chk("t1_gap_busy", 32'(busy), 32'h1);
        step(1);
        chk("t1_done_clr", 32'(pkt_done), 32'h0);
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // 2: all four requesting, round-robin order with a gap between grants
        do_reset();
        req = 4'b1111;
        step(1);
        chk("t2_g0", 32'(grant), 32'h1);
        for (int g = 0; g < 4; g++) begin
            beats_until_release(g, 40, nbeats);
            chk("t2_beats", 32'(nbeats), 32'd20);
            step(1);
            chk("t2_gap_grant", 32'(grant), 32'h0);
            step(1);
            chk("t2_next_grant", 32'(grant), 32'(4'b0001 << ((g + 1) % 4)));
        end
        chk("t2_count", pkt_count, 32'd4);
        req = '0;
        beats_until_release(0, 40, nbeats);
        step(2);

        // 3: port_en gating, then drop port_en mid-packet
        do_reset();
        port_en = 1'b0;
        req = 4'b0100;
        step(3);
        chk("t3_gated", 32'(grant), 32'h0);
        port_en = 1'b1;
        step(1);
        chk("t3_grant", 32'(grant), 32'h4);
        req = '0;
        in_valid = 4'b0100;
        step(5);
        port_en = 1'b0;
        beats_until_release(2, 40, nbeats);
        chk("t3_beats_rest", 32'(nbeats), 32'd15);
        chk("t3_count", pkt_count, 32'd1);
        chk("t3_last", 32'(last_src), 32'h2);
        port_en = 1'b1;
        step(2);

        // 4: length clamping at both ends
        do_reset();
        pkt_len[0 +: 32] = 32'd3;
        req = 4'b0001;
        step(1);
        chk("t4_grant_short", 32'(grant), 32'h1);
        pkt_len[0 +: 32] = 32'd1000;
        beats_until_release(0, 40, nbeats);
        chk("t4_short_beats", 32'(nbeats), 32'd10);
        step(2);
        chk("t4_grant_long", 32'(grant), 32'h1);
        req = '0;
        beats_until_release(0, 300, nbeats);
        chk("t4_long_beats", 32'(nbeats), 32'd255);
        chk("t4_count", pkt_count, 32'd2);
        pkt_len[0 +: 32] = 32'd20;
        step(2);

        // 5: source 1 with stalls while source 2 strobes
        do_reset();
        req = 4'b0010;
        step(1);
        chk("t5_grant", 32'(grant), 32'h2);
        req = '0;
        for (int b = 0; b < 19; b++) begin
            in_valid = 4'b0010 | ((b % 2 == 0) ? 4'b0100 : 4'b0000);
            step(1);
            for (int s = 0; s < 3; s++) begin
                in_valid = (s % 2 == 0) ? 4'b0100 : 4'b0000;
                step(1);
            end
        end
        in_valid = '0;
        chk("t5_held_19", 32'(grant), 32'h2);
        chk("t5_nodone_19", 32'(pkt_done), 32'h0);
        in_valid = 4'b0110;
        step(1);
        in_valid = '0;
        chk("t5_release", 32'(grant), 32'h0);
        chk("t5_done", 32'(pkt_done), 32'h1);
        chk("t5_count", pkt_count, 32'd1);
        step(2);

        // 6: reset mid-packet aborts and clears the pointer
        req = 4'b0100;
        step(1);
        chk("t6_grant", 32'(grant), 32'h4);
        req = '0;
        in_valid = 4'b0100;
        step(7);
        chk("t6_mid_busy", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_grant", 32'(grant), 32'h0);
        chk("t6_async_busy", 32'(busy), 32'h0);
        chk("t6_count", pkt_count, 32'h0);
        in_valid = '0;
        step(1);
        reset = 1'b1;
        req = 4'b0011;
        step(1);
        chk("t6_regrant", 32'(grant), 32'h1);
        chk("t6_last", 32'(last_src), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
